// File: rtl/mem_access_unit_if.sv
// Controller- and RAM-facing signal bundle of the memory access stage.
// The slave modport is the access unit itself; master is the controller/RAM side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MEM_OE;
  logic                  MEM_WS;
  logic [1:0]            RAM_SEL;
  logic [2:0]            REG_DATA_SEL;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [31:0]           WDATA;

  logic                  BUS_REQ;
  logic                  BUS_WE;
  logic [ADDR_WIDTH-1:0] BUS_ADDR;
  logic [3:0]            BUS_BE;
  logic [31:0]           BUS_WDATA;
  logic [31:0]           BUS_RDATA;
  logic                  BUS_ACK;

  logic [31:0]           MDR;
  logic                  MEM_BUSY;
  logic                  MEM_DONE;
  logic                  ADDR_ERR;
  logic                  BUS_ERR;

  modport slave (
    input  MEM_OE, MEM_WS, RAM_SEL, REG_DATA_SEL, ADDR, WDATA, BUS_RDATA, BUS_ACK,
    output BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA,
    output MDR, MEM_BUSY, MEM_DONE, ADDR_ERR, BUS_ERR
  );

  modport master (
    output MEM_OE, MEM_WS, RAM_SEL, REG_DATA_SEL, ADDR, WDATA, BUS_RDATA, BUS_ACK,
    input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA,
    input  MDR, MEM_BUSY, MEM_DONE, ADDR_ERR, BUS_ERR
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access stage: turns controller strobes into a req/ack word-bus transaction.
// Optional bus-ack timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t                state_reg, state_next;
  logic                  req_reg, req_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [3:0]            be_reg, be_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [2:0]            ltype_reg, ltype_next;
  logic [1:0]            lane_reg, lane_next;
  logic [31:0]           mdr_reg, mdr_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  aerr_reg, aerr_next;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  berr_reg, berr_next;
`endif

  // Request decode
  size_t       acc_size;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] wdata_byte_rep;
  logic [31:0] wdata_half_rep;

  // Load alignment
  logic [7:0]  rd_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_byte_rep[8*gi +: 8] = bus.WDATA[7:0];
      assign wdata_half_rep[8*gi +: 8] = bus.WDATA[8*(gi % 2) +: 8];
      assign rd_lane[gi]               = bus.BUS_RDATA[8*gi +: 8];
    end
  endgenerate

  // Width comes from RAM_SEL on writes and REG_DATA_SEL on reads.
  always_comb begin
    acc_size = SZ_WORD;
    if (bus.MEM_WS) begin
      case (bus.RAM_SEL)
        2'b01:   acc_size = SZ_HALF;
        2'b10:   acc_size = SZ_BYTE;
        default: acc_size = SZ_WORD;
      endcase
    end else begin
      case (bus.REG_DATA_SEL)
        3'b001, 3'b010: acc_size = SZ_BYTE;
        3'b011, 3'b100: acc_size = SZ_HALF;
        default:        acc_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wdata  = bus.WDATA;
    case (acc_size)
      SZ_WORD: misaligned = |bus.ADDR[1:0];
      SZ_HALF: misaligned = bus.ADDR[0];
      default: misaligned = 1'b0;
    endcase
    if (bus.MEM_WS) begin
      case (acc_size)
        SZ_BYTE: begin
          req_be    = 4'b0001 << bus.ADDR[1:0];
          req_wdata = wdata_byte_rep;
        end
        SZ_HALF: begin
          req_be    = bus.ADDR[1] ? 4'b1100 : 4'b0011;
          req_wdata = wdata_half_rep;
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = bus.WDATA;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = rd_lane[lane_reg];
    ld_half = lane_reg[1] ? bus.BUS_RDATA[31:16] : bus.BUS_RDATA[15:0];
    case (ltype_reg)
      3'b001:  ld_data = {24'd0, ld_byte};
      3'b010:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b011:  ld_data = {16'd0, ld_half};
      3'b100:  ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.BUS_RDATA;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    ltype_next = ltype_reg;
    lane_next  = lane_reg;
    mdr_next   = mdr_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    aerr_next  = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_next   = cnt_reg;
    berr_next  = 1'b0;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
        busy_next  = 1'b0;
        if (bus.MEM_OE || bus.MEM_WS) begin
          if ((bus.MEM_OE && bus.MEM_WS) || misaligned) begin
            aerr_next = 1'b1;
          end else begin
            state_next = ST_WAIT;
            req_next   = 1'b1;
            busy_next  = 1'b1;
            we_next    = bus.MEM_WS;
            addr_next  = {bus.ADDR[ADDR_WIDTH-1:2], 2'b00};
            be_next    = req_be;
            wdata_next = req_wdata;
            ltype_next = bus.REG_DATA_SEL;
            lane_next  = bus.ADDR[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (bus.BUS_ACK) begin
          if (!we_reg) begin
            mdr_next = ld_data;
          end
          state_next = ST_DONE;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          berr_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= 4'd0;
      wdata_reg <= 32'd0;
      ltype_reg <= 3'd0;
      lane_reg  <= 2'd0;
      mdr_reg   <= 32'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      aerr_reg  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_reg   <= '0;
      berr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      ltype_reg <= ltype_next;
      lane_reg  <= lane_next;
      mdr_reg   <= mdr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      aerr_reg  <= aerr_next;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      berr_reg  <= berr_next;
`endif
    end
  end

  assign bus.BUS_REQ   = req_reg;
  assign bus.BUS_WE    = we_reg;
  assign bus.BUS_ADDR  = addr_reg;
  assign bus.BUS_BE    = be_reg;
  assign bus.BUS_WDATA = wdata_reg;
  assign bus.MDR       = mdr_reg;
  assign bus.MEM_BUSY  = busy_reg;
  assign bus.MEM_DONE  = done_reg;
  assign bus.ADDR_ERR  = aerr_reg;
`ifdef MEM_ACCESS_TIMEOUT_EN
  assign bus.BUS_ERR   = berr_reg;
`else
  assign bus.BUS_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized loads/stores
// compared against a byte-address arithmetic model of the memory stage.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) ifc ();

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mdr = 32'd0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Controller must never strobe while a transaction is outstanding.
  always @(negedge CLK) begin
    #1;
    if (ifc.BUS_REQ === 1'b1) begin
      checks++;
      assert ((ifc.MEM_OE | ifc.MEM_WS) === 1'b0) else begin
        errors++;
        $error("FAIL strobe_in_wait: observed=%b expected=0", ifc.MEM_OE | ifc.MEM_WS);
      end
    end
  end

  function automatic int acc_size(input bit rd, input logic [1:0] rs, input logic [2:0] ts);
    if (!rd) return (rs == 2'd1) ? 2 : (rs == 2'd2) ? 1 : 4;
    case (ts)
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] t, input logic [31:0] rd, input logic [1:0] a);
    logic [31:0] b, h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd1:    return b;
      3'd2:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      default: return rd;
    endcase
  endfunction

  task automatic clear_strobes();
    ifc.MEM_OE = 1'b0;
    ifc.MEM_WS = 1'b0;
  endtask

  task automatic idle_cycle(input bit ack_noise);
    @(negedge CLK);
    clear_strobes();
    ifc.BUS_ACK   = ack_noise;
    ifc.BUS_RDATA = $urandom;
    @(posedge CLK); #1;
    chk("idle_done", ifc.MEM_DONE, 0);
    chk("idle_req", ifc.BUS_REQ, 0);
    chk("idle_mdr", ifc.MDR, exp_mdr);
  endtask

  task automatic access(input bit rd, input logic [1:0] rs, input logic [2:0] ts,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int dly);
    int sz, m, busy;
    logic [3:0]  be;
    logic [31:0] wexp;
    sz = acc_size(rd, rs, ts);
    @(negedge CLK);
    ifc.MEM_OE = rd; ifc.MEM_WS = !rd;
    ifc.RAM_SEL = rs; ifc.REG_DATA_SEL = ts;
    ifc.ADDR = a; ifc.WDATA = wd; ifc.BUS_ACK = 1'b0;
    @(posedge CLK); #1;
    if ((a % sz) != 0) begin
      chk("misalign_err", ifc.ADDR_ERR, 1);
      chk("misalign_req", ifc.BUS_REQ, 0);
      @(negedge CLK); clear_strobes();
      @(posedge CLK); #1;
      chk("misalign_pulse", ifc.ADDR_ERR, 0);
      chk("misalign_req2", ifc.BUS_REQ, 0);
      chk("misalign_mdr", ifc.MDR, exp_mdr);
      $display("txn %s size=%0d addr=%h -> rejected", rd ? "RD" : "WR", sz, a);
      return;
    end
    m = (1 << sz) - 1;
    be = rd ? 4'hF : 4'(m << (a & 3));
    wexp = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
    chk("req", ifc.BUS_REQ, 1);
    chk("we", ifc.BUS_WE, !rd);
    chk("bus_addr", ifc.BUS_ADDR, a & ~32'd3);
    chk("be", ifc.BUS_BE, be);
    if (!rd) chk("wdata", ifc.BUS_WDATA, wexp);
    chk("addr_err_legal", ifc.ADDR_ERR, 0);
    busy = ifc.MEM_BUSY ? 1 : 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge CLK); clear_strobes(); ifc.BUS_ACK = 1'b0; ifc.BUS_RDATA = $urandom;
      @(posedge CLK); #1;
      chk("req_hold", ifc.BUS_REQ, 1);
      chk("done_early", ifc.MEM_DONE, 0);
      if (ifc.MEM_BUSY) busy++;
    end
    @(negedge CLK); clear_strobes(); ifc.BUS_ACK = 1'b1; ifc.BUS_RDATA = rdat;
    @(posedge CLK); #1;
    if (rd) exp_mdr = load_val(ts, rdat, a[1:0]);
    chk("done", ifc.MEM_DONE, 1);
    chk("req_drop", ifc.BUS_REQ, 0);
    chk("busy_drop", ifc.MEM_BUSY, 0);
    chk("mdr", ifc.MDR, exp_mdr);
    chk("busy_cycles", busy, dly + 1);
    $display("txn %s size=%0d addr=%h wd=%h rdata=%h dly=%0d mdr=%h",
             rd ? "RD" : "WR", sz, a, wd, rdat, dly, ifc.MDR);
  endtask

  initial begin
    int rd, rs, ts, dly, sz;
    logic [31:0] a;
    ifc.MEM_OE = 0; ifc.MEM_WS = 0; ifc.RAM_SEL = 0; ifc.REG_DATA_SEL = 0;
    ifc.ADDR = 0; ifc.WDATA = 0; ifc.BUS_RDATA = 0; ifc.BUS_ACK = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", ifc.BUS_REQ, 0);
    chk("rst_busy", ifc.MEM_BUSY, 0);
    chk("rst_done", ifc.MEM_DONE, 0);
    chk("rst_aerr", ifc.ADDR_ERR, 0);
    chk("rst_berr", ifc.BUS_ERR, 0);
    chk("rst_mdr", ifc.MDR, 0);
    chk("rst_be", ifc.BUS_BE, 0);
    chk("rst_addr", ifc.BUS_ADDR, 0);
    $display("txn RESET released");
    @(negedge CLK); RST = 1'b1;

    access(1, 2'd0, 3'd2, 32'h1003, 32'd0, 32'h80FF_1234, 3);
    chk("tp_lb", ifc.MDR, 32'hFFFF_FF80);
    access(1, 2'd0, 3'd3, 32'h2002, 32'd0, 32'hBEEF_0001, 1);
    chk("tp_lhu", ifc.MDR, 32'h0000_BEEF);
    access(1, 2'd0, 3'd4, 32'h2002, 32'd0, 32'hBEEF_0001, 0);
    chk("tp_lh", ifc.MDR, 32'hFFFF_BEEF);
    idle_cycle(1'b1);
    access(1, 2'd0, 3'd0, 32'h2000, 32'd0, 32'hBEEF_0001, 2);
    chk("tp_lw", ifc.MDR, 32'hBEEF_0001);
    access(0, 2'd2, 3'd0, 32'h0005, 32'h0000_00A5, 32'hDEAD_DEAD, 1);
    chk("tp_sb_mdr", ifc.MDR, 32'hBEEF_0001);
    access(0, 2'd1, 3'd0, 32'h0006, 32'h0000_1234, 32'hDEAD_DEAD, 0);
    chk("tp_sh_mdr", ifc.MDR, 32'hBEEF_0001);
    access(1, 2'd0, 3'd0, 32'h0002, 32'd0, 32'd0, 0);
    access(0, 2'd1, 3'd0, 32'h0001, 32'h5555, 32'd0, 0);

    @(negedge CLK); ifc.MEM_OE = 1; ifc.MEM_WS = 1; ifc.ADDR = 32'h10;
    @(posedge CLK); #1;
    chk("both_err", ifc.ADDR_ERR, 1);
    chk("both_req", ifc.BUS_REQ, 0);
    @(negedge CLK); clear_strobes();
    @(posedge CLK); #1;
    chk("both_pulse", ifc.ADDR_ERR, 0);
    $display("txn RD+WR strobes -> rejected");

    for (int n = 0; n < 40; n++) begin
      rd = $urandom_range(0, 1);
      rs = $urandom_range(0, 3);
      ts = $urandom_range(0, 7);
      a  = $urandom_range(0, 65535);
      sz = acc_size(rd[0], rs[1:0], ts[2:0]);
      if ($urandom_range(0, 4) != 0) a = a & ~(sz - 1);
      dly = $urandom_range(0, 3);
      access(rd[0], rs[1:0], ts[2:0], a, $urandom, $urandom, dly);
      if ($urandom_range(0, 2) == 0) idle_cycle($urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of a pending read
    @(negedge CLK);
    ifc.MEM_OE = 1; ifc.REG_DATA_SEL = 3'd0; ifc.ADDR = 32'h40; ifc.BUS_ACK = 0;
    @(posedge CLK); #1;
    chk("rst_wait_req", ifc.BUS_REQ, 1);
    @(negedge CLK); clear_strobes();
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    chk("async_req", ifc.BUS_REQ, 0);
    chk("async_busy", ifc.MEM_BUSY, 0);
    chk("async_mdr", ifc.MDR, 0);
    exp_mdr = 32'd0;
    $display("txn RESET mid-wait");
    @(negedge CLK); RST = 1'b1;
    access(1, 2'd0, 3'd0, 32'h44, 32'd0, 32'h0BAD_F00D, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int cyc;
      bit seen;
      cyc = 0; seen = 0;
      @(negedge CLK);
      ifc.MEM_OE = 1; ifc.REG_DATA_SEL = 3'd0; ifc.ADDR = 32'h80; ifc.BUS_ACK = 0;
      @(posedge CLK); #1;
      chk("to_req", ifc.BUS_REQ, 1);
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge CLK); clear_strobes();
        @(posedge CLK); #1;
        cyc++;
        chk("to_no_done", ifc.MEM_DONE, 0);
        if (ifc.BUS_ERR) seen = 1;
      end
      chk("to_seen", seen, 1);
      chk("to_cycles", cyc, TO + 1);
      chk("to_req_drop", ifc.BUS_REQ, 0);
      chk("to_busy_drop", ifc.MEM_BUSY, 0);
      chk("to_mdr", ifc.MDR, exp_mdr);
      @(posedge CLK); #1;
      chk("to_pulse", ifc.BUS_ERR, 0);
      $display("txn RD addr=00000080 -> timeout after %0d cycles", cyc);
      access(1, 2'd0, 3'd1, 32'h81, 32'd0, 32'h0000_7F00, 0);
    end
`else
    access(1, 2'd0, 3'd0, 32'h300, 32'd0, 32'h1357_9BDF, 300);
    chk("no_to_berr", ifc.BUS_ERR, 0);
`endif

    idle_cycle(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory access stage directly downstream of the multi-cycle sequence controller.
- Converts the controller's one-cycle MEM_OE/MEM_WS strobes, RAM_SEL store width and REG_DATA_SEL load type into a req/ack transaction on the external word-wide RAM bus.
- Generates byte enables, aligns and extends load data into the memory data register (MDR), and raises stall, done and error indications back to the controller.

Parameters:
- ADDR_WIDTH, 32, byte address width; BUS_ADDR is word-aligned.
- TIMEOUT_CYCLES, 255, maximum wait cycles for BUS_ACK (used only with TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- MEM_OE  in  1  read strobe from controller
- MEM_WS  in  1  write strobe from controller
- RAM_SEL  in  2  store width: 00 word, 01 half, 10 byte, 11 treated as word
- REG_DATA_SEL  in  3  load type: 000 LW, 001 LBU, 010 LB, 011 LHU, 100 LH, others treated as LW
- ADDR  in  ADDR_WIDTH  byte address (ALU output)
- WDATA  in  32  store data (rt)
- BUS_REQ  out  1  transaction request
- BUS_WE  out  1  1 = write
- BUS_ADDR  out  ADDR_WIDTH  {ADDR[ADDR_WIDTH-1:2],2'b00}
- BUS_BE  out  4  byte-lane enables, lane k = bits [8k+7:8k]
- BUS_WDATA  out  32  lane-replicated store data
- BUS_RDATA  in  32  read data, valid when BUS_ACK=1
- BUS_ACK  in  1  transaction complete
- MDR  out  32  aligned, extended load result
- MEM_BUSY  out  1  stall to controller
- MEM_DONE  out  1  one-cycle completion pulse
- ADDR_ERR  out  1  one-cycle misalignment/illegal-request pulse
- BUS_ERR  out  1  one-cycle timeout pulse

Behaviour:
- Reset: all outputs and internal registers are 0, and the FSM enters IDLE.
- Reset asserted mid-transaction: BUS_REQ drops immediately (asynchronous reset), the transaction is abandoned, and MDR is cleared.
- FSM states: IDLE, WAIT, DONE. All bus and status outputs are registered.

IDLE:
- MEM_OE and MEM_WS both 1: ADDR_ERR pulses the next cycle, no bus access, stay in IDLE.
- Alignment check:
  - Word access requires ADDR[1:0]=00.
  - Half access requires ADDR[0]=0.
  - Byte access is always aligned.
  - Width is taken from RAM_SEL for writes and from REG_DATA_SEL for reads.
- Misaligned request: ADDR_ERR pulses the next cycle, no bus access, stay in IDLE, MDR unchanged.
- Legal request in cycle N:
  - Latch BUS_ADDR, BUS_WE, BUS_BE, BUS_WDATA, the load type and ADDR[1:0].
  - From N+1: BUS_REQ=1 and MEM_BUSY=1; the FSM is in WAIT.

WAIT:
- BUS_REQ and all bus outputs are held stable.
- Cycle with BUS_ACK=1:
  - For reads, MDR captures the aligned BUS_RDATA.
  - Next cycle: DONE, BUS_REQ=0, MEM_BUSY=0, MEM_DONE=1.
- Minimum latency: strobe in cycle N, ack in N+1, MEM_DONE in N+2.

DONE:
- Lasts one cycle, then IDLE. A strobe arriving during DONE is accepted as in IDLE.
- Strobes during WAIT are ignored; the controller must not issue them (bench assertion).

Store lanes (little-endian):
- Byte: BE = 1<<ADDR[1:0], data = {4{WDATA[7:0]}}.
- Half: BE = 0011 if ADDR[1]=0, else 1100; data = {2{WDATA[15:0]}}.
- Word: BE = 1111, data = WDATA.

Load extraction:
- Byte lane is ADDR[1:0]; half lane is ADDR[1].
- LBU/LHU zero-extend; LB/LH sign-extend from bit 7/15.
- LW passes BUS_RDATA unchanged.
- BUS_BE for reads is 1111.

Other rules:
- MDR holds its value until the next completed read; writes never alter MDR.
- BUS_ACK sampled while in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: next cycle BUS_REQ=0, MEM_BUSY=0, BUS_ERR=1 for one cycle, FSM returns to IDLE, MDR unchanged, MEM_DONE not asserted.
  - Ack arriving in the same cycle the count reaches TIMEOUT_CYCLES: the ack wins.
- Undefined: no counter; WAIT persists until BUS_ACK; BUS_ERR is tied to 0.

Test Plan:
- LB, ADDR=0x1003, BUS_RDATA=0x80FF_1234, ack after 3 cycles -> BUS_BE=1111, BUS_ADDR=0x1000, MDR=0xFFFF_FF80, one MEM_DONE pulse, MEM_BUSY high for 4 cycles.
- LHU, ADDR=0x2002, BUS_RDATA=0xBEEF_0001 -> MDR=0x0000_BEEF; LH same -> MDR=0xFFFF_BEEF; LW -> MDR=0xBEEF_0001.
- SB, ADDR=0x0005, WDATA=0x0000_00A5 -> BUS_WE=1, BUS_BE=0010, BUS_WDATA=0xA5A5_A5A5; SH at 0x0006, WDATA=0x1234 -> BE=1100, WDATA=0x1234_1234; MDR unchanged.
- Misaligned LW at 0x0002, SH at 0x0001, and MEM_OE=MEM_WS=1 -> ADDR_ERR pulse each time, BUS_REQ never asserted.
- RST driven low while in WAIT -> BUS_REQ, MEM_BUSY and MDR go to 0 without a clock edge; after release, a new LW completes normally.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> BUS_ERR single pulse, no MEM_DONE, FSM back in IDLE; without the macro the request stays pending for 300 cycles until ack.
